led_pattern_sequencer: RTL and testbench



---
 rtl/led_pattern_sequencer.sv | 214 +++++++++++++++++++++
 tb/tb_led_pattern_sequencer.sv | 369 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/led_pattern_sequencer.sv
// Autonomous LED pattern sequencer: a CSR slave holds the pattern table and timing,
// and a write-only master steps the table out to the LED PIO.
module led_pattern_sequencer #(
    parameter int PATTERN_DEPTH  = 8,
    parameter int DATA_WIDTH     = 4,
    parameter int PRESCALE_WIDTH = 24
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [3:0]  s_address,
    input  logic        s_chipselect,
    input  logic        s_write_n,
    input  logic [31:0] s_writedata,
    output logic [31:0] s_readdata,
    output logic [1:0]  m_address,
    output logic        m_chipselect,
    output logic        m_write_n,
    output logic [31:0] m_writedata,
    output logic        irq
);

    localparam int IDX_W = 3;

    typedef enum logic [1:0] {IDLE, STROBE, HOLD} state_t;

    state_t                    state_q, state_d;
    logic                      enable_q, enable_d;
    logic                      loop_q, loop_d;
    logic                      irq_en_q, irq_en_d;
    logic                      done_q, done_d;
    logic                      irq_q, irq_d;
    logic [IDX_W-1:0]          index_q, index_d;
    logic [PRESCALE_WIDTH-1:0] period_q, period_d;
    logic [PRESCALE_WIDTH-1:0] eff_period_q, eff_period_d;
    logic [PRESCALE_WIDTH-1:0] cnt_q, cnt_d;
    logic [3:0]                length_q, length_d;
    logic [3:0]                eff_len_q, eff_len_d;
    logic [DATA_WIDTH-1:0]     pattern_q [PATTERN_DEPTH];
    logic [DATA_WIDTH-1:0]     pattern_d [PATTERN_DEPTH];
    logic                      m_chipselect_q, m_chipselect_d;
    logic                      m_write_n_q, m_write_n_d;
    logic [31:0]               m_writedata_q, m_writedata_d;

    logic             wr_en, ctrl_wr, status_wr, period_wr, length_wr, pattern_wr;
    logic             pattern_hit, busy, step_end, emit;
    logic [IDX_W-1:0] pattern_sel;
    logic             unused_wdata;

    assign wr_en       = s_chipselect & ~s_write_n;
    assign ctrl_wr     = wr_en && (s_address == 4'd0);
    assign status_wr   = wr_en && (s_address == 4'd1);
    assign period_wr   = wr_en && (s_address == 4'd2);
    assign length_wr   = wr_en && (s_address == 4'd3);
    assign pattern_hit = s_address[3] && ({1'b0, s_address[2:0]} < 4'(PATTERN_DEPTH));
    assign pattern_wr  = wr_en && pattern_hit;
    assign pattern_sel = s_address[2:0];
    assign busy        = (state_q != IDLE);
    assign unused_wdata = ^s_writedata;

    always_comb begin
        state_d        = state_q;
        enable_d       = enable_q;
        loop_d         = loop_q;
        irq_en_d       = irq_en_q;
        done_d         = done_q;
        index_d        = index_q;
        period_d       = period_q;
        eff_period_d   = eff_period_q;
        cnt_d          = cnt_q;
        length_d       = length_q;
        eff_len_d      = eff_len_q;
        pattern_d      = pattern_q;
        m_chipselect_d = 1'b0;
        m_write_n_d    = 1'b1;
        m_writedata_d  = m_writedata_q;
        step_end       = 1'b0;
        emit           = 1'b0;

        if (period_wr) period_d = s_writedata[PRESCALE_WIDTH-1:0];
        if (length_wr) length_d = s_writedata[3:0];
        if (pattern_wr) pattern_d[pattern_sel] = s_writedata[DATA_WIDTH-1:0];
        if (status_wr && s_writedata[1]) done_d = 1'b0;
        if (ctrl_wr) begin
            loop_d   = s_writedata[1];
            irq_en_d = s_writedata[2];
        end

        // Period and length are frozen into shadow copies at start so mid-run CSR edits wait for the next run.
        case (state_q)
            IDLE: begin
                if (ctrl_wr) begin
                    enable_d = s_writedata[0];
                    if (s_writedata[0]) begin
                        index_d      = '0;
                        done_d       = 1'b0;
                        eff_period_d = (period_q == '0) ? PRESCALE_WIDTH'(1) : period_q;
                        if (length_q == 4'd0)
                            eff_len_d = 4'd1;
                        else if (length_q > 4'(PATTERN_DEPTH))
                            eff_len_d = 4'(PATTERN_DEPTH);
                        else
                            eff_len_d = length_q;
                        state_d = STROBE;
                        emit    = 1'b1;
                    end
                end
            end
            STROBE: begin
                cnt_d = eff_period_q - PRESCALE_WIDTH'(1);
                if (eff_period_q == PRESCALE_WIDTH'(1))
                    step_end = 1'b1;
                else
                    state_d = HOLD;
            end
            HOLD: begin
                cnt_d = cnt_q - PRESCALE_WIDTH'(1);
                if (cnt_q == PRESCALE_WIDTH'(1)) step_end = 1'b1;
            end
            default: state_d = IDLE;
        endcase

        // An abort beats a coinciding step end and leaves done untouched.
        if (busy && ctrl_wr && !s_writedata[0]) begin
            enable_d = 1'b0;
            state_d  = IDLE;
            step_end = 1'b0;
        end

        if (step_end) begin
            if ({1'b0, index_q} < (eff_len_q - 4'd1)) begin
                index_d = index_q + 3'd1;
                state_d = STROBE;
                emit    = 1'b1;
            end else if (loop_q) begin
                index_d = '0;
                state_d = STROBE;
                emit    = 1'b1;
            end else begin
                done_d   = 1'b1;
                enable_d = 1'b0;
                state_d  = IDLE;
            end
        end

        if (emit) begin
            m_chipselect_d                  = 1'b1;
            m_write_n_d                     = 1'b0;
            m_writedata_d                   = '0;
            m_writedata_d[DATA_WIDTH-1:0]   = pattern_d[index_d];
        end

        irq_d = done_d & irq_en_d;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q        <= IDLE;
            enable_q       <= 1'b0;
            loop_q         <= 1'b0;
            irq_en_q       <= 1'b0;
            done_q         <= 1'b0;
            irq_q          <= 1'b0;
            index_q        <= '0;
            period_q       <= '0;
            eff_period_q   <= '0;
            cnt_q          <= '0;
            length_q       <= '0;
            eff_len_q      <= '0;
            m_chipselect_q <= 1'b0;
            m_write_n_q    <= 1'b1;
            m_writedata_q  <= '0;
            for (int i = 0; i < PATTERN_DEPTH; i++) pattern_q[i] <= '0;
        end else begin
            state_q        <= state_d;
            enable_q       <= enable_d;
            loop_q         <= loop_d;
            irq_en_q       <= irq_en_d;
            done_q         <= done_d;
            irq_q          <= irq_d;
            index_q        <= index_d;
            period_q       <= period_d;
            eff_period_q   <= eff_period_d;
            cnt_q          <= cnt_d;
            length_q       <= length_d;
            eff_len_q      <= eff_len_d;
            m_chipselect_q <= m_chipselect_d;
            m_write_n_q    <= m_write_n_d;
            m_writedata_q  <= m_writedata_d;
            pattern_q      <= pattern_d;
        end
    end

    always_comb begin
        s_readdata = '0;
        case (s_address)
            4'd0: s_readdata[2:0] = {irq_en_q, loop_q, enable_q};
            4'd1: begin
                s_readdata[0]   = busy;
                s_readdata[1]   = done_q;
                s_readdata[6:4] = index_q;
            end
            4'd2: s_readdata[PRESCALE_WIDTH-1:0] = period_q;
            4'd3: s_readdata[3:0] = length_q;
            default: if (pattern_hit) s_readdata[DATA_WIDTH-1:0] = pattern_q[pattern_sel];
        endcase
    end

    assign m_address    = 2'b00;
    assign m_chipselect = m_chipselect_q;
    assign m_write_n    = m_write_n_q;
    assign m_writedata  = m_writedata_q;
    assign irq          = irq_q;

endmodule

// File: tb/tb_led_pattern_sequencer.sv
// Directed testbench for led_pattern_sequencer: CSR access, strobe timing, looping,
// abort, live pattern update and asynchronous reset.
module tb_led_pattern_sequencer;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [3:0]  s_address = '0;
    logic        s_chipselect = 1'b0;
    logic        s_write_n = 1'b1;
    logic [31:0] s_writedata = '0;
    logic [31:0] s_readdata;
    logic [1:0]  m_address;
    logic        m_chipselect;
    logic        m_write_n;
    logic [31:0] m_writedata;
    logic        irq;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    logic [31:0] strobe_data[$];
    int          strobe_cyc[$];

    led_pattern_sequencer #(
        .PATTERN_DEPTH(8), .DATA_WIDTH(4), .PRESCALE_WIDTH(24)
    ) dut (
        .clk(clk), .reset_n(reset_n),
        .s_address(s_address), .s_chipselect(s_chipselect), .s_write_n(s_write_n),
        .s_writedata(s_writedata), .s_readdata(s_readdata),
        .m_address(m_address), .m_chipselect(m_chipselect), .m_write_n(m_write_n),
        .m_writedata(m_writedata), .irq(irq)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Every PIO write is one cycle long, so one sample per falling edge logs each exactly once.
    always @(negedge clk) begin
        if (reset_n && m_chipselect && !m_write_n) begin
            strobe_data.push_back(m_writedata);
            strobe_cyc.push_back(cyc);
        end
    end

    initial begin
        #400000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic csr_write(input logic [3:0] a, input logic [31:0] d);
        @(negedge clk);
        s_address = a; s_writedata = d; s_chipselect = 1'b1; s_write_n = 1'b0;
        @(negedge clk);
        s_chipselect = 1'b0; s_write_n = 1'b1; s_writedata = '0;
    endtask

    task automatic csr_read(input logic [3:0] a, output logic [31:0] d);
        @(negedge clk);
        s_address = a; s_chipselect = 1'b1;
        #1 d = s_readdata;
        s_chipselect = 1'b0;
    endtask

    task automatic clear_log();
        strobe_data.delete();
        strobe_cyc.delete();
    endtask

    task automatic test_reset();
        logic [31:0] rd;
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (m_chipselect !== 1'b0 || m_write_n !== 1'b1 || irq !== 1'b0) begin
            failures++;
            $display("[TB] FAIL reset_outputs: cs=%b wn=%b irq=%b want cs=0 wn=1 irq=0", m_chipselect, m_write_n, irq);
        end
        checks++;
        if (m_address !== 2'b00 || m_writedata !== 32'h0) begin
            failures++;
            $display("[TB] FAIL reset_master: addr=%h data=%h want 0 0", m_address, m_writedata);
        end
        reset_n = 1'b1;
        for (int a = 0; a < 16; a++) begin
            csr_read(4'(a), rd);
            checks++;
            if (rd !== 32'h0) begin
                failures++;
                $display("[TB] FAIL reset_csr[%0d]: got %h want 00000000", a, rd);
            end
        end
    endtask

    task automatic test_oneshot_irq();
        logic [31:0] rd;
        logic [31:0] exp_data [3] = '{32'h1, 32'h2, 32'h4};
        csr_write(4'd8, 32'h1);
        csr_write(4'd9, 32'h2);
        csr_write(4'd10, 32'h4);
        csr_write(4'd2, 32'd5);
        csr_write(4'd3, 32'd3);
        clear_log();
        csr_write(4'd0, 32'h5);
        for (int i = 0; i < 200 && !irq; i++) @(negedge clk);
        checks++;
        if (irq !== 1'b1) begin
            failures++;
            $display("[TB] FAIL oneshot_irq_timeout: irq=%b want 1", irq);
        end
        checks++;
        if (strobe_data.size() != 3) begin
            failures++;
            $display("[TB] FAIL oneshot_count: got %0d strobes want 3", strobe_data.size());
        end else begin
            for (int k = 0; k < 3; k++) begin
                checks++;
                if (strobe_data[k] !== exp_data[k]) begin
                    failures++;
                    $display("[TB] FAIL oneshot_data[%0d]: got %h want %h", k, strobe_data[k], exp_data[k]);
                end
            end
            for (int k = 1; k < 3; k++) begin
                checks++;
                if (strobe_cyc[k] - strobe_cyc[k-1] != 5) begin
                    failures++;
                    $display("[TB] FAIL oneshot_spacing[%0d]: got %0d cycles want 5", k, strobe_cyc[k] - strobe_cyc[k-1]);
                end
            end
        end
        csr_read(4'd1, rd);
        checks++;
        if (rd !== 32'h22) begin
            failures++;
            $display("[TB] FAIL oneshot_status: got %h want 00000022", rd);
        end
        csr_read(4'd0, rd);
        checks++;
        if (rd !== 32'h4) begin
            failures++;
            $display("[TB] FAIL oneshot_ctrl: got %h want 00000004", rd);
        end
        checks++;
        if (m_writedata !== 32'h4) begin
            failures++;
            $display("[TB] FAIL oneshot_led_hold: got %h want 00000004", m_writedata);
        end
        csr_write(4'd1, 32'h2);
        checks++;
        if (irq !== 1'b0) begin
            failures++;
            $display("[TB] FAIL w1c_irq: got %b want 0", irq);
        end
        csr_read(4'd1, rd);
        checks++;
        if (rd !== 32'h20) begin
            failures++;
            $display("[TB] FAIL w1c_status: got %h want 00000020", rd);
        end
    endtask

    task automatic test_min_period_len();
        logic [31:0] rd;
        logic        seen_done = 1'b0;
        csr_write(4'd2, 32'd0);
        csr_write(4'd3, 32'd0);
        csr_write(4'd8, 32'hF);
        clear_log();
        csr_write(4'd0, 32'h1);
        for (int i = 0; i < 50 && !seen_done; i++) begin
            csr_read(4'd1, rd);
            seen_done = rd[1];
        end
        repeat (5) @(negedge clk);
        checks++;
        if (!seen_done) begin
            failures++;
            $display("[TB] FAIL minlen_done_timeout: done=%b want 1", seen_done);
        end
        checks++;
        if (strobe_data.size() != 1 || strobe_data[0] !== 32'hF) begin
            failures++;
            $display("[TB] FAIL minlen_strobe: got %0d strobes first=%h want 1 strobe 0000000f",
                     strobe_data.size(), (strobe_data.size() > 0) ? strobe_data[0] : 32'hx);
        end
        csr_read(4'd1, rd);
        checks++;
        if (rd !== 32'h02 || irq !== 1'b0) begin
            failures++;
            $display("[TB] FAIL minlen_status: got %h irq=%b want 00000002 irq=0", rd, irq);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] rd;
        logic        data_ok = 1'b1;
        logic        gap_ok = 1'b1;
        csr_write(4'd3, 32'd2);
        csr_write(4'd2, 32'd1);
        csr_write(4'd9, 32'h2);
        clear_log();
        csr_write(4'd0, 32'h3);
        repeat (8) @(negedge clk);
        checks++;
        if (strobe_data.size() < 8) begin
            failures++;
            $display("[TB] FAIL b2b_count: got %0d strobes want at least 8", strobe_data.size());
        end else begin
            for (int k = 0; k < 8; k++) begin
                if (strobe_data[k] !== ((k % 2 == 0) ? 32'hF : 32'h2)) data_ok = 1'b0;
                if (k > 0 && strobe_cyc[k] - strobe_cyc[k-1] != 1) gap_ok = 1'b0;
            end
            checks++;
            if (!data_ok) begin
                failures++;
                $display("[TB] FAIL b2b_alternate: got %h %h %h %h want f 2 f 2",
                         strobe_data[0], strobe_data[1], strobe_data[2], strobe_data[3]);
            end
            checks++;
            if (!gap_ok) begin
                failures++;
                $display("[TB] FAIL b2b_spacing: got %0d %0d %0d want consecutive cycles",
                         strobe_cyc[0], strobe_cyc[1], strobe_cyc[2]);
            end
        end
        csr_write(4'd0, 32'h2);
        clear_log();
        repeat (10) @(negedge clk);
        checks++;
        if (strobe_data.size() != 0 || m_chipselect !== 1'b0) begin
            failures++;
            $display("[TB] FAIL abort_quiet: got %0d strobes cs=%b want 0 strobes cs=0", strobe_data.size(), m_chipselect);
        end
        csr_read(4'd1, rd);
        checks++;
        if (rd[1:0] !== 2'b00) begin
            failures++;
            $display("[TB] FAIL abort_status: got busy/done=%b want 00", rd[1:0]);
        end
        csr_read(4'd0, rd);
        checks++;
        if (rd !== 32'h2) begin
            failures++;
            $display("[TB] FAIL abort_ctrl: got %h want 00000002", rd);
        end
    endtask

    task automatic test_wrap_live_pattern();
        int          n0;
        logic        seq_ok = 1'b1;
        logic        gap_ok = 1'b1;
        logic        seen_a = 1'b0;
        logic [31:0] want;
        for (int i = 0; i < 8; i++) csr_write(4'(8 + i), 32'(i));
        csr_write(4'd3, 32'd9);
        csr_write(4'd2, 32'd2);
        clear_log();
        csr_write(4'd0, 32'h3);
        repeat (20) @(negedge clk);
        csr_write(4'd11, 32'hA);
        n0 = strobe_data.size();
        repeat (24) @(negedge clk);
        csr_write(4'd0, 32'h0);
        repeat (3) @(negedge clk);
        checks++;
        if (strobe_data.size() < 20) begin
            failures++;
            $display("[TB] FAIL wrap_count: got %0d strobes want at least 20", strobe_data.size());
        end else begin
            checks++;
            if (strobe_data[7] !== 32'h7 || strobe_data[8] !== 32'h0) begin
                failures++;
                $display("[TB] FAIL wrap_7_to_0: got %h then %h want 7 then 0", strobe_data[7], strobe_data[8]);
            end
            for (int k = 0; k < strobe_data.size(); k++) begin
                if (k > 0 && strobe_cyc[k] - strobe_cyc[k-1] != 2) gap_ok = 1'b0;
                if (k % 8 != 3) begin
                    want = 32'(k % 8);
                    if (strobe_data[k] !== want) seq_ok = 1'b0;
                end else if (k + 1 < n0) begin
                    if (strobe_data[k] !== 32'h3) seq_ok = 1'b0;
                end else if (k > n0) begin
                    if (strobe_data[k] !== 32'hA) seq_ok = 1'b0;
                    else seen_a = 1'b1;
                end
            end
            checks++;
            if (!seq_ok) begin
                failures++;
                $display("[TB] FAIL wrap_sequence: got index-ordered data not matching k%%8 with live 0xa at index 3 after write (n0=%0d)", n0);
            end
            checks++;
            if (!seen_a) begin
                failures++;
                $display("[TB] FAIL live_pattern: got no 0xa strobe want index-3 strobe carrying 0xa");
            end
            checks++;
            if (!gap_ok) begin
                failures++;
                $display("[TB] FAIL wrap_spacing: got irregular gap want 2 cycles between strobes");
            end
        end
    endtask

    task automatic test_reset_mid_strobe();
        logic [31:0] rd;
        logic        found = 1'b0;
        csr_write(4'd8, 32'h5);
        csr_write(4'd2, 32'd4);
        csr_write(4'd3, 32'd2);
        csr_write(4'd0, 32'h1);
        for (int i = 0; i < 20 && !found; i++) begin
            if (m_chipselect === 1'b1) found = 1'b1;
            else @(negedge clk);
        end
        checks++;
        if (!found) begin
            failures++;
            $display("[TB] FAIL rst_find_strobe: got no strobe want one within 20 cycles");
        end
        reset_n = 1'b0;
        #1;
        checks++;
        if (m_chipselect !== 1'b0 || m_write_n !== 1'b1 || m_writedata !== 32'h0 || irq !== 1'b0) begin
            failures++;
            $display("[TB] FAIL rst_async: cs=%b wn=%b data=%h irq=%b want 0 1 0 0", m_chipselect, m_write_n, m_writedata, irq);
        end
        @(negedge clk);
        reset_n = 1'b1;
        clear_log();
        repeat (20) @(negedge clk);
        checks++;
        if (strobe_data.size() != 0) begin
            failures++;
            $display("[TB] FAIL rst_no_restart: got %0d strobes want 0", strobe_data.size());
        end
        csr_read(4'd0, rd);
        checks++;
        if (rd !== 32'h0) begin
            failures++;
            $display("[TB] FAIL rst_ctrl: got %h want 00000000", rd);
        end
        csr_read(4'd2, rd);
        checks++;
        if (rd !== 32'h0) begin
            failures++;
            $display("[TB] FAIL rst_period: got %h want 00000000", rd);
        end
        csr_read(4'd8, rd);
        checks++;
        if (rd !== 32'h0) begin
            failures++;
            $display("[TB] FAIL rst_pattern0: got %h want 00000000", rd);
        end
    endtask

    initial begin
        test_reset();
        test_oneshot_irq();
        test_min_period_len();
        test_back_to_back();
        test_wrap_live_pattern();
        test_reset_mid_strobe();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
